// File: rtl/oldland_dbus_pkg.sv
// rtl/oldland_dbus_pkg.sv - shared state, response and width constants for the Oldland data-bus SRAM
package oldland_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    localparam int BYTESEL_W = 4;

endpackage

// File: rtl/oldland_bytewise_ram.sv
// rtl/oldland_bytewise_ram.sv - single-port synchronous RAM with per-byte write enables
module oldland_bytewise_ram import oldland_dbus_pkg::*; #(
    parameter int addr_bits = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [BYTESEL_W-1:0] be,
    input  logic [addr_bits-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**addr_bits];

    // Contents are never cleared; a read returns the word one cycle later, a write only touches enabled lanes.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BYTESEL_W; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/oldland_dbus_sram.sv
// rtl/oldland_dbus_sram.sv - Oldland data-bus responder serving an on-chip SRAM window
module oldland_dbus_sram import oldland_dbus_pkg::*; #(
    parameter int          mem_words_bits = 10,
    parameter logic [29:0] base_word      = 30'h0,
    parameter int          ro_words       = 0,
    parameter int          wait_states    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_access,
    input  logic [29:0]          d_addr,
    input  logic [BYTESEL_W-1:0] d_bytesel,
    input  logic                 d_wr_en,
    input  logic [31:0]          d_wr_val,
    output logic [31:0]          d_data,
    output logic                 d_ack,
    output logic                 d_error
);

    localparam int IW = mem_words_bits;
    localparam logic [3:0] CNT_LOAD = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

    state_t state, state_nx;

    logic [3:0]           cnt;
    logic [IW-1:0]        idx_q;
    logic                 hit_q, ro_q, wr_q;
    logic [BYTESEL_W-1:0] bs_q;
    logic [31:0]          wv_q;
    logic                 ack_q, err_q;
    logic                 ack_nx, err_nx;
    logic                 ram_en;
    logic                 rsp_type;
    logic [31:0]          ram_rdata;

    // Window decode: the unsigned difference wraps below base_word, so one compare covers both ends.
    logic [29:0]   diff;
    logic          hit_c, ro_c;
    logic [IW-1:0] idx_c;
    assign diff  = d_addr - base_word;
    assign hit_c = (diff >> IW) == 30'd0;
    assign idx_c = diff[IW-1:0];
    assign ro_c  = 32'(idx_c) < $unsigned(ro_words);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, RAM strobe and the response to register on the XFER exit.
    always_comb begin
        state_nx = state;
        ram_en   = 1'b0;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        rsp_type = (hit_q && !(wr_q && ro_q)) ? RSP_OK : RSP_ERR;
        case (state)
            IDLE: begin
                if (d_access) begin
                    state_nx = (wait_states > 0) ? WAIT : XFER;
                end
            end
            WAIT: begin
                if (!d_access) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                ram_en = (rsp_type == RSP_OK);
                if (d_access) begin
                    state_nx = RESP;
                    ack_nx   = (rsp_type == RSP_OK);
                    err_nx   = (rsp_type == RSP_ERR);
                end else begin
                    state_nx = IDLE;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance and run the wait counter; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 4'd0;
            idx_q <= '0;
            hit_q <= 1'b0;
            ro_q  <= 1'b0;
            wr_q  <= 1'b0;
            bs_q  <= '0;
            wv_q  <= 32'd0;
        end else if (state == IDLE && d_access) begin
            cnt   <= CNT_LOAD;
            idx_q <= idx_c;
            hit_q <= hit_c;
            ro_q  <= ro_c;
            wr_q  <= d_wr_en;
            bs_q  <= d_bytesel;
            wv_q  <= d_wr_val;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Registered one-cycle response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_nx;
            err_q <= err_nx;
        end
    end

    oldland_bytewise_ram #(
        .addr_bits (IW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_q),
        .be    (bs_q),
        .addr  (idx_q),
        .wdata (wv_q),
        .rdata (ram_rdata)
    );

    assign d_ack   = ack_q;
    assign d_error = err_q;
    assign d_data  = (ack_q && !wr_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_oldland_dbus_sram.sv
// tb/tb_oldland_dbus_sram.sv - self-checking bench for oldland_dbus_sram
module tb_oldland_dbus_sram;

    localparam logic [29:0] BASE0 = 30'h100;
    localparam logic [29:0] BASE1 = 30'h3C0;
    localparam int          WORDS = 64;

    logic [29:0] base_a [2];
    int          ro_a   [2];
    int          ws_a   [2];

    logic clk;
    logic rst_n;

    logic        acc  [2];
    logic [29:0] addr [2];
    logic [3:0]  bsel [2];
    logic        wen  [2];
    logic [31:0] wval [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    oldland_dbus_sram #(
        .mem_words_bits (6),
        .base_word      (BASE0),
        .ro_words       (4),
        .wait_states    (0)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_access  (acc[0]),
        .d_addr    (addr[0]),
        .d_bytesel (bsel[0]),
        .d_wr_en   (wen[0]),
        .d_wr_val  (wval[0]),
        .d_data    (rdat[0]),
        .d_ack     (ack[0]),
        .d_error   (err[0])
    );

    oldland_dbus_sram #(
        .mem_words_bits (6),
        .base_word      (BASE1),
        .ro_words       (0),
        .wait_states    (3)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_access  (acc[1]),
        .d_addr    (addr[1]),
        .d_bytesel (bsel[1]),
        .d_wr_en   (wen[1]),
        .d_wr_val  (wval[1]),
        .d_data    (rdat[1]),
        .d_ack     (ack[1]),
        .d_error   (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mm [2][WORDS];
    logic [3:0]  kn [2][WORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: window hit, read-only region and byte-lane merge from plain arithmetic.
    task automatic model(input int d, input logic [29:0] a, input logic [3:0] bs, input logic wr,
                         input logic [31:0] wv, output logic ea, output logic ee,
                         output logic [31:0] ed, output logic cd);
        logic [29:0] diff;
        int idx;
        bit hit, ro;
        diff = a - base_a[d];
        hit  = diff < 30'(WORDS);
        idx  = int'(diff % 30'(WORDS));
        ro   = idx < ro_a[d];
        ed = 32'd0;
        cd = 1'b1;
        if (!hit || (wr && ro)) begin
            ea = 1'b0;
            ee = 1'b1;
        end else begin
            ea = 1'b1;
            ee = 1'b0;
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (bs[b]) begin
                        mm[d][idx][8*b +: 8] = wv[8*b +: 8];
                        kn[d][idx][b] = 1'b1;
                    end
                end
            end else begin
                ed = mm[d][idx];
                cd = (kn[d][idx] == 4'hF);
            end
        end
    endtask

    task automatic start(input int d, input logic [29:0] a, input logic [3:0] bs,
                         input logic wr, input logic [31:0] wv);
        acc[d]  = 1'b1;
        addr[d] = a;
        bsel[d] = bs;
        wen[d]  = wr;
        wval[d] = wv;
    endtask

    // Issue one request and check response kind, data, latency and that the pulse lasts one cycle.
    task automatic run(input int d, input logic [29:0] a, input logic [3:0] bs, input logic wr,
                       input logic [31:0] wv, input logic ea, input logic ee,
                       input logic [31:0] ed, input logic cd, input string name);
        int lat;
        logic ra, re;
        logic [31:0] rd;
        start(d, a, bs, wr, wv);
        lat = 0;
        ra = 1'b0;
        re = 1'b0;
        rd = 32'd0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack[d] || err[d]) begin
                ra = ack[d];
                re = err[d];
                rd = rdat[d];
                break;
            end
        end
        acc[d]  = 1'b0;
        addr[d] = 30'h3FFF_FFFF;
        wval[d] = 32'hFFFF_FFFF;
        chk({name, " latency"}, 32'(lat), 32'(2 + ws_a[d]));
        chk({name, " ack/err"}, {30'd0, ra, re}, {30'd0, ea, ee});
        if (cd) begin
            chk({name, " data"}, rd, ed);
        end
        @(posedge clk);
        #1;
        chk({name, " pulse end"}, {30'd0, ack[d], err[d]}, 32'd0);
    endtask

    task automatic quiet(input int d, input int n, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ack[d] || err[d]) seen = 1'b1;
        end
        chk({name, " no response"}, {31'd0, seen}, 32'd0);
    endtask

    typedef struct {
        logic [29:0] a;
        logic [3:0]  bs;
        logic        wr;
        logic [31:0] wv;
        logic        ea;
        logic        ee;
        logic [31:0] ed;
        logic        cd;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic ea, ee, cd;
        logic [31:0] ed;
        logic [29:0] ra;
        logic [3:0]  rbs;
        logic        rwr;
        logic [31:0] rwv;

        base_a[0] = BASE0; base_a[1] = BASE1;
        ro_a[0]   = 4;     ro_a[1]   = 0;
        ws_a[0]   = 0;     ws_a[1]   = 3;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < WORDS; i++) begin
                mm[d][i] = 32'd0;
                kn[d][i] = 4'd0;
            end
            acc[d] = 1'b0; addr[d] = '0; bsel[d] = '0; wen[d] = 1'b0; wval[d] = '0;
        end

        vecs[0]  = '{30'h105, 4'hF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[1]  = '{30'h105, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
        vecs[2]  = '{30'h106, 4'hF, 1'b1, 32'h11223344, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[3]  = '{30'h106, 4'h4, 1'b1, 32'h00AA0000, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[4]  = '{30'h106, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11AA3344, 1'b1};
        vecs[5]  = '{30'h106, 4'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[6]  = '{30'h106, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11AA3344, 1'b1};
        vecs[7]  = '{30'h140, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[8]  = '{30'h0FF, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vecs[9]  = '{30'h103, 4'hF, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'h0,        1'b1};
        vecs[10] = '{30'h104, 4'hF, 1'b1, 32'h0BADF00D, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{30'h104, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0BADF00D, 1'b1};
        vecs[12] = '{30'h103, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vecs[13] = '{30'h13F, 4'hF, 1'b1, 32'hCAFE0001, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[14] = '{30'h13F, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'hCAFE0001, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset ack", {31'd0, ack[d]}, 32'd0);
            chk("reset err", {31'd0, err[d]}, 32'd0);
            chk("reset data", rdat[d], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            model(0, vecs[i].a, vecs[i].bs, vecs[i].wr, vecs[i].wv, ea, ee, ed, cd);
            run(0, vecs[i].a, vecs[i].bs, vecs[i].wr, vecs[i].wv,
                vecs[i].ea, vecs[i].ee, vecs[i].ed, vecs[i].cd, $sformatf("vec%0d", i));
        end

        model(1, 30'h3C9, 4'hF, 1'b1, 32'h55AA55AA, ea, ee, ed, cd);
        run(1, 30'h3C9, 4'hF, 1'b1, 32'h55AA55AA, 1'b1, 1'b0, 32'h0, 1'b1, "ws3 store");
        run(1, 30'h3C9, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0, 32'h55AA55AA, 1'b1, "ws3 load");
        run(1, 30'h3BF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, "ws3 miss");

        model(1, 30'h3CA, 4'hF, 1'b1, 32'h01020304, ea, ee, ed, cd);
        run(1, 30'h3CA, 4'hF, 1'b1, 32'h01020304, 1'b1, 1'b0, 32'h0, 1'b1, "pre abort");
        start(1, 30'h3CA, 4'hF, 1'b1, 32'hFFFF0000);
        @(posedge clk);
        #1;
        acc[1] = 1'b0;
        quiet(1, 6, "abort wait");
        run(1, 30'h3CA, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0, 32'h01020304, 1'b1, "after wait abort");

        start(1, 30'h3CA, 4'hF, 1'b1, 32'hA5A5A5A5);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        acc[1] = 1'b0;
        model(1, 30'h3CA, 4'hF, 1'b1, 32'hA5A5A5A5, ea, ee, ed, cd);
        quiet(1, 6, "abort xfer");
        run(1, 30'h3CA, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, "after xfer abort");

        start(1, 30'h3C9, 4'hF, 1'b1, 32'h12345678);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid ack", {31'd0, ack[1]}, 32'd0);
        chk("rst mid err", {31'd0, err[1]}, 32'd0);
        chk("rst mid data", rdat[1], 32'd0);
        acc[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1, 30'h3C9, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0, 32'h55AA55AA, 1'b1, "post reset load");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                ra  = base_a[d] + 30'($urandom_range(0, WORDS + 3)) - 30'd2;
                rbs = 4'($urandom);
                rwr = 1'($urandom);
                rwv = $urandom;
                model(d, ra, rbs, rwr, rwv, ea, ee, ed, cd);
                run(d, ra, rbs, rwr, rwv, ea, ee, ed, cd, $sformatf("rand d%0d #%0d", d, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
